// File: rtl/tetris_pkg.sv
// Shared board geometry and types for the Tetris display path.
// Contents:
//   BOARD_COLS / BOARD_ROWS / CELL_W - board geometry and cell width
//   COL_W                            - width of a column index
//   cell_t, row_t                    - one cell, one packed board row
//   piece_x_t, piece_y_t             - 4-block tetromino coordinates
//   fetch_state_t                    - row fetcher sequencing states
package tetris_pkg;

   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 20;
   localparam int CELL_W     = 16;
   localparam int COL_W      = $clog2(BOARD_COLS);

   typedef logic [CELL_W-1:0]         cell_t;
   typedef cell_t [BOARD_COLS-1:0]    row_t;
   typedef logic [3:0][3:0]           piece_x_t;
   typedef logic [3:0][4:0]           piece_y_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/board_row_fetcher_if.sv
// Mapper-side handshake between the VGA colour mapper and the row fetcher.
// Signals:
//   LD_Row   - row-load request level from the mapper
//   rowNum   - board row to load, taken on the LD_Row rising edge
//   Row      - committed row presented to the mapper
//   rowReady - one-cycle pulse when Row changes
//   busy     - fetch in progress
// Modports: master = mapper, slave = row fetcher.
interface board_row_fetcher_if;
   import tetris_pkg::*;

   logic       LD_Row;
   logic [7:0] rowNum;
   row_t       Row;
   logic       rowReady;
   logic       busy;

   modport master (output LD_Row, output rowNum,
                   input  Row, input rowReady, input busy);
   modport slave  (input  LD_Row, input rowNum,
                   output Row, output rowReady, output busy);

endinterface

// File: rtl/piece_overlay.sv
// Combinational hit test of one board cell against the falling piece.
// Ports:
//   row, col     - board coordinate being captured
//   piece_valid  - piece present (snapshot)
//   piece_x/y    - block coordinates (snapshot)
//   piece_color  - cell value for piece blocks
//   hit          - some block occupies (row, col)
//   cell_out     - piece_color on a hit, zero otherwise
module piece_overlay
   import tetris_pkg::*;
(
   input  logic [7:0]       row,
   input  logic [COL_W-1:0] col,
   input  logic             piece_valid,
   input  piece_x_t         piece_x,
   input  piece_y_t         piece_y,
   input  cell_t            piece_color,
   output logic             hit,
   output cell_t            cell_out
);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // Several blocks on the same cell simply OR together.
         if (piece_valid && ({3'b000, piece_y[i]} == row) && (piece_x[i] == col))
            hit = 1'b1;
      end
      cell_out = hit ? piece_color : '0;
   end

endmodule

// File: rtl/board_row_fetcher.sv
// Fetches one board row from the synchronous board RAM, overlays the
// falling piece and commits it to a stable double-buffered output row.
// Ports:
//   Clk, reset              - clock, synchronous active-high reset
//   mif (slave)             - LD_Row/rowNum request, Row/rowReady/busy result
//   piece_valid/x/y/color   - falling piece, snapshotted per request
//   ram_addr, ram_rd_en     - board RAM read port (registered)
//   ram_rdata               - RAM data, one cycle after the address edge
module board_row_fetcher
   import tetris_pkg::*;
#(
   parameter int ADDR_W = 8
)(
   input  logic                Clk,
   input  logic                reset,
   board_row_fetcher_if.slave  mif,
   input  logic                piece_valid,
   input  piece_x_t            piece_x,
   input  piece_y_t            piece_y,
   input  cell_t               piece_color,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_rd_en,
   input  cell_t               ram_rdata
);

   if (BOARD_ROWS * BOARD_COLS > (1 << ADDR_W)) begin : g_addr_chk
      $error("board_row_fetcher: board does not fit in ADDR_W address bits");
   end

   function automatic logic [ADDR_W-1:0] calc_addr(input logic [7:0] r,
                                                   input logic [COL_W-1:0] c);
      logic [15:0] a;
      a = 16'(r) * 16'(BOARD_COLS) + 16'(c);
      return a[ADDR_W-1:0];
   endfunction

   fetch_state_t     state;
   logic             ld_q;
   logic             req;
   logic             req_in_rng;
   logic [7:0]       row_q;
   logic             oor_q;
   logic [COL_W-1:0] col;
   logic             snap_valid;
   piece_x_t         snap_x;
   piece_y_t         snap_y;
   cell_t            snap_color;
   logic             cap_vld_p1;
   logic [COL_W-1:0] cap_col_p1;
   row_t             shadow;
   cell_t            ram_cell;
   cell_t            ovl_cell;
   logic             ovl_hit;
   cell_t            cap_cell;

   assign req        = mif.LD_Row & ~ld_q;
   assign req_in_rng = (mif.rowNum < 8'(BOARD_ROWS));
   assign mif.busy   = (state != IDLE);

   // Out-of-range rows never touch the RAM and read as empty.
   assign ram_cell = oor_q ? '0 : ram_rdata;
   assign cap_cell = ovl_hit ? ovl_cell : ram_cell;

   piece_overlay u_overlay (
      .row         (row_q),
      .col         (cap_col_p1),
      .piece_valid (snap_valid),
      .piece_x     (snap_x),
      .piece_y     (snap_y),
      .piece_color (snap_color),
      .hit         (ovl_hit),
      .cell_out    (ovl_cell)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         state        <= IDLE;
         ld_q         <= 1'b0;
         row_q        <= '0;
         oor_q        <= 1'b0;
         col          <= '0;
         snap_valid   <= 1'b0;
         snap_x       <= '0;
         snap_y       <= '0;
         snap_color   <= '0;
         cap_vld_p1   <= 1'b0;
         cap_col_p1   <= '0;
         shadow       <= '0;
         mif.Row      <= '0;
         mif.rowReady <= 1'b0;
         ram_addr     <= '0;
         ram_rd_en    <= 1'b0;
      end else begin
         ld_q         <= mif.LD_Row;
         mif.rowReady <= 1'b0;

         // p0 -> p1: tag which column the RAM is returning next cycle
         cap_vld_p1 <= (state == READ);
         cap_col_p1 <= col;

         // p1 -> p2: capture RAM data (or piece) into the shadow row
         if (cap_vld_p1)
            shadow[cap_col_p1] <= cap_cell;

         case (state)
            READ: begin
               if (col == COL_W'(BOARD_COLS - 1)) begin
                  state     <= DRAIN;
                  ram_rd_en <= 1'b0;
               end else begin
                  col <= col + 1'b1;
                  if (!oor_q)
                     ram_addr <= calc_addr(row_q, col + 1'b1);
               end
            end
            DRAIN:  state <= COMMIT;
            COMMIT: begin
               mif.Row      <= shadow;
               mif.rowReady <= 1'b1;
               state        <= IDLE;
            end
            default: ;
         endcase

         // A new request restarts from column 0 in any state; in COMMIT the
         // commit above still lands because Row reads the old shadow.
         // Killing the in-flight tag keeps the old row's data out.
         if (req) begin
            state      <= READ;
            row_q      <= mif.rowNum;
            oor_q      <= ~req_in_rng;
            col        <= '0;
            ram_addr   <= req_in_rng ? calc_addr(mif.rowNum, '0) : '0;
            ram_rd_en  <= req_in_rng;
            snap_valid <= piece_valid;
            snap_x     <= piece_x;
            snap_y     <= piece_y;
            snap_color <= piece_color;
            cap_vld_p1 <= 1'b0;
            shadow     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_board_row_fetcher.sv
module tb_board_row_fetcher;
   import tetris_pkg::*;

   localparam int ADDR_W = 8;

   logic              Clk = 1'b0;
   logic              reset;
   logic              piece_valid;
   piece_x_t          piece_x;
   piece_y_t          piece_y;
   cell_t             piece_color;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd_en;
   cell_t             ram_rdata = '0;
   cell_t             mem [256];

   int errors    = 0;
   int checks    = 0;
   int ready_cnt = 0;
   int rd_cnt    = 0;

   board_row_fetcher_if mif ();

   board_row_fetcher #(.ADDR_W(ADDR_W)) dut (
      .Clk         (Clk),
      .reset       (reset),
      .mif         (mif),
      .piece_valid (piece_valid),
      .piece_x     (piece_x),
      .piece_y     (piece_y),
      .piece_color (piece_color),
      .ram_addr    (ram_addr),
      .ram_rd_en   (ram_rd_en),
      .ram_rdata   (ram_rdata)
   );

   always #5 Clk = ~Clk;

   // Synchronous board RAM, one cycle read latency
   always @(posedge Clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

   // Pulse / access counters (values seen just before each edge)
   always @(posedge Clk) begin
      if (mif.rowReady === 1'b1) ready_cnt++;
      if (ram_rd_en === 1'b1) rd_cnt++;
   end

   // Reference: the row the mapper should see for a request on row r
   function automatic row_t model_row(input int r, input logic pv, input piece_x_t px,
                                      input piece_y_t py, input cell_t pc);
      row_t res;
      for (int c = 0; c < BOARD_COLS; c++) begin
         res[c] = (r < BOARD_ROWS) ? mem[r * BOARD_COLS + c] : '0;
         if (pv)
            for (int b = 0; b < 4; b++)
               if (int'(py[b]) == r && int'(px[b]) == c) res[c] = pc;
      end
      return res;
   endfunction

   task automatic fill_pattern;
      for (int a = 0; a < 256; a++) mem[a] = '0;
      for (int r = 0; r < BOARD_ROWS; r++)
         for (int c = 0; c < BOARD_COLS; c++)
            mem[r * BOARD_COLS + c] = {4'h0, 4'(r), 4'(c), 4'hA};
   endtask

   // Leaves LD_Row high; the request edge is the next posedge.
   task automatic request(input int row);
      mif.LD_Row = 1'b0;
      @(negedge Clk);
      mif.rowNum = 8'(row);
      mif.LD_Row = 1'b1;
   endtask

   task automatic wait_ready(output int lat);
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (mif.rowReady === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      mif.LD_Row = 1'b0; mif.rowNum = '0;
      piece_valid = 1'b0; piece_x = '0; piece_y = '0; piece_color = '0;
      repeat (3) @(negedge Clk);
      checks++; if (mif.Row !== '0) begin errors++; $display("FAIL reset_row: got %h want 0", mif.Row); end
      checks++; if (mif.rowReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", mif.rowReady); end
      checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
      checks++; if (ram_rd_en !== 1'b0 || ram_addr !== '0) begin errors++; $display("FAIL reset_ram: got en=%b addr=%h want 0/0", ram_rd_en, ram_addr); end
      reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_single_fetch;
      row_t prev, exp;
      int   lat = -1, r0, rd0;
      logic addr_ok = 1'b1, hold_ok = 1'b1;
      prev = mif.Row; r0 = ready_cnt; rd0 = rd_cnt;
      request(3);
      exp = model_row(3, piece_valid, piece_x, piece_y, piece_color);
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (i < BOARD_COLS && (ram_addr !== 8'(30 + i) || ram_rd_en !== 1'b1)) addr_ok = 1'b0;
         if (i < 12 && (mif.Row !== prev || mif.busy !== 1'b1)) hold_ok = 1'b0;
         if (mif.rowReady === 1'b1 && lat < 0) lat = i;
      end
      mif.LD_Row = 1'b0;
      checks++; if (lat !== 12) begin errors++; $display("FAIL single_latency: got %0d want 12", lat); end
      checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_seq: got bad want 30..39 with rd_en"); end
      checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL single_hold_busy: got Row change or busy low want held/busy"); end
      checks++; if (mif.Row !== exp) begin errors++; $display("FAIL single_row: got %h want %h", mif.Row, exp); end
      checks++; if (mif.Row[7] !== 16'h037A) begin errors++; $display("FAIL single_cell7: got %h want 037a", mif.Row[7]); end
      checks++; if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", ready_cnt - r0); end
      checks++; if (rd_cnt - rd0 !== 10) begin errors++; $display("FAIL single_reads: got %0d want 10", rd_cnt - rd0); end
      checks++; if (mif.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", mif.busy); end
   endtask

   task automatic test_overlay;
      row_t exp;
      int   lat;
      piece_valid = 1'b1;
      piece_x = {4'd6, 4'd5, 4'd5, 4'd4};
      piece_y = {5'd6, 5'd6, 5'd5, 5'd5};
      piece_color = 16'h0F00;
      request(5);
      exp = model_row(5, piece_valid, piece_x, piece_y, piece_color);
      wait_ready(lat);
      mif.LD_Row = 1'b0;
      checks++; if (lat !== 12) begin errors++; $display("FAIL overlay_latency: got %0d want 12", lat); end
      checks++; if (mif.Row !== exp) begin errors++; $display("FAIL overlay_row: got %h want %h", mif.Row, exp); end
      checks++; if (mif.Row[4] !== 16'h0F00 || mif.Row[5] !== 16'h0F00) begin errors++; $display("FAIL overlay_hits: got %h %h want 0f00 0f00", mif.Row[4], mif.Row[5]); end
      checks++; if (mif.Row[6] !== 16'h056A) begin errors++; $display("FAIL overlay_row6_ignored: got %h want 056a", mif.Row[6]); end
   endtask

   task automatic test_piece_move;
      row_t exp;
      int   lat = -1;
      piece_x = {4'd6, 4'd5, 4'd5, 4'd4};
      request(5);
      exp = model_row(5, piece_valid, piece_x, piece_y, piece_color);
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (i == 3) piece_x = {4{4'd9}};
         if (mif.rowReady === 1'b1 && lat < 0) lat = i;
      end
      mif.LD_Row = 1'b0;
      checks++; if (lat !== 12) begin errors++; $display("FAIL move_latency: got %0d want 12", lat); end
      checks++; if (mif.Row !== exp) begin errors++; $display("FAIL move_row: got %h want %h", mif.Row, exp); end
      checks++; if (mif.Row[9] !== 16'h059A) begin errors++; $display("FAIL move_col9: got %h want 059a", mif.Row[9]); end
      piece_valid = 1'b0;
   endtask

   task automatic test_abort;
      row_t prev, exp;
      int   lat = -1, n = 0;
      logic hold_ok = 1'b1;
      prev = mif.Row;
      request(2);
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (mif.rowReady === 1'b1) begin n++; if (lat < 0) lat = i - 5; end
         if (i < 17 && mif.Row !== prev) hold_ok = 1'b0;
         if (i == 3) mif.LD_Row = 1'b0;
         if (i == 4) begin mif.rowNum = 8'd7; mif.LD_Row = 1'b1; end
      end
      mif.LD_Row = 1'b0;
      exp = model_row(7, piece_valid, piece_x, piece_y, piece_color);
      checks++; if (n !== 1) begin errors++; $display("FAIL abort_pulses: got %0d want 1", n); end
      checks++; if (lat !== 12) begin errors++; $display("FAIL abort_latency: got %0d want 12", lat); end
      checks++; if (hold_ok !== 1'b1) begin errors++; $display("FAIL abort_hold: got Row change want held"); end
      checks++; if (mif.Row !== exp) begin errors++; $display("FAIL abort_row: got %h want %h", mif.Row, exp); end
   endtask

   task automatic test_out_of_range;
      int lat, rd0;
      rd0 = rd_cnt;
      request(20);
      wait_ready(lat);
      mif.LD_Row = 1'b0;
      checks++; if (lat !== 12) begin errors++; $display("FAIL oor_latency: got %0d want 12", lat); end
      checks++; if (mif.Row !== '0) begin errors++; $display("FAIL oor_row: got %h want 0", mif.Row); end
      checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL oor_reads: got %0d want 0", rd_cnt - rd0); end
   endtask

   task automatic test_commit_request;
      row_t e1, e2, g1;
      int   l1 = -1, l2 = -1, n = 0;
      g1 = '0;
      request(1);
      e1 = model_row(1, piece_valid, piece_x, piece_y, piece_color);
      e2 = model_row(8, piece_valid, piece_x, piece_y, piece_color);
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (mif.rowReady === 1'b1) begin
            n++;
            if (l1 < 0) begin l1 = i; g1 = mif.Row; end
            else if (l2 < 0) l2 = i;
         end
         if (i == 9) mif.LD_Row = 1'b0;
         if (i == 11) begin mif.rowNum = 8'd8; mif.LD_Row = 1'b1; end
      end
      mif.LD_Row = 1'b0;
      checks++; if (l1 !== 12 || l2 !== 24) begin errors++; $display("FAIL commit_req_timing: got %0d/%0d want 12/24", l1, l2); end
      checks++; if (n !== 2) begin errors++; $display("FAIL commit_req_pulses: got %0d want 2", n); end
      checks++; if (g1 !== e1) begin errors++; $display("FAIL commit_req_first: got %h want %h", g1, e1); end
      checks++; if (mif.Row !== e2) begin errors++; $display("FAIL commit_req_second: got %h want %h", mif.Row, e2); end
   endtask

   task automatic test_reset_mid;
      row_t exp;
      int   lat, r0;
      request(4);
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (i == 5) begin reset = 1'b1; mif.LD_Row = 1'b0; end
      end
      @(negedge Clk);
      checks++; if (mif.Row !== '0 || mif.busy !== 1'b0 || mif.rowReady !== 1'b0) begin errors++; $display("FAIL resetmid_state: got Row=%h busy=%b rdy=%b want 0/0/0", mif.Row, mif.busy, mif.rowReady); end
      reset = 1'b0;
      r0 = ready_cnt;
      repeat (20) @(negedge Clk);
      checks++; if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL resetmid_no_commit: got %0d want 0", ready_cnt - r0); end
      request(4);
      exp = model_row(4, piece_valid, piece_x, piece_y, piece_color);
      wait_ready(lat);
      mif.LD_Row = 1'b0;
      checks++; if (lat !== 12) begin errors++; $display("FAIL resetmid_latency: got %0d want 12", lat); end
      checks++; if (mif.Row !== exp) begin errors++; $display("FAIL resetmid_row: got %h want %h", mif.Row, exp); end
   endtask

   task automatic test_random;
      row_t exp;
      int   lat, rd0, row;
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      for (int t = 0; t < 10; t++) begin
         row = int'($urandom_range(0, 23));
         piece_valid = 1'($urandom_range(0, 1));
         for (int b = 0; b < 4; b++) begin
            piece_x[b] = 4'($urandom_range(0, BOARD_COLS - 1));
            piece_y[b] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 23)) : 5'(row);
         end
         piece_color = 16'($urandom);
         rd0 = rd_cnt;
         request(row);
         exp = model_row(row, piece_valid, piece_x, piece_y, piece_color);
         wait_ready(lat);
         mif.LD_Row = 1'b0;
         repeat (2) @(negedge Clk);
         checks++; if (lat !== 12) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 12", t, lat); end
         checks++; if (mif.Row !== exp) begin errors++; $display("FAIL rand_row[%0d] r=%0d: got %h want %h", t, row, mif.Row, exp); end
         checks++; if (rd_cnt - rd0 !== ((row < BOARD_ROWS) ? 10 : 0)) begin errors++; $display("FAIL rand_reads[%0d] r=%0d: got %0d want %0d", t, row, rd_cnt - rd0, (row < BOARD_ROWS) ? 10 : 0); end
      end
   endtask

   initial begin
      reset = 1'b1;
      mif.LD_Row = 1'b0;
      mif.rowNum = '0;
      fill_pattern();
      test_reset();
      test_single_fetch();
      test_overlay();
      test_piece_move();
      test_abort();
      test_out_of_range();
      test_commit_request();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
